// File: rtl/id_stage_p_pkg.sv
// Shared decode definitions for the ID stage: opcode encoding, per-opcode
// control record and the opcode-to-control lookup.
package id_stage_p_pkg;

    typedef enum logic [5:0] {
        OP_ADD  = 6'h00, OP_ADDI = 6'h01, OP_SUB  = 6'h02, OP_SUBI = 6'h03,
        OP_MUL  = 6'h04, OP_MULI = 6'h05, OP_OR   = 6'h06, OP_ORI  = 6'h07,
        OP_AND  = 6'h08, OP_ANDI = 6'h09, OP_XOR  = 6'h0A, OP_XORI = 6'h0B,
        OP_LDW  = 6'h0C, OP_STW  = 6'h0D, OP_BZ   = 6'h0E, OP_BEQ  = 6'h0F,
        OP_JR   = 6'h10, OP_HALT = 6'h11
    } opcode_e;

    typedef enum logic [1:0] {
        RD_NONE    = 2'd0,
        RD_FROM_RD = 2'd1,
        RD_FROM_RT = 2'd2
    } rd_sel_e;

    // use_rt also marks rt as a real source for load-use detection
    typedef struct packed {
        logic    use_rs;
        logic    use_rt;
        rd_sel_e rd_sel;
        logic    use_imm;
        logic    branch;
        logic    mem_read;
        logic    mem_to_reg;
        logic    mem_write;
        logic    halt;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;
    localparam ctrl_t CTRL_RTYPE = '{use_rs: 1'b1, use_rt: 1'b1, rd_sel: RD_FROM_RD,
        use_imm: 1'b0, branch: 1'b0, mem_read: 1'b0, mem_to_reg: 1'b0, mem_write: 1'b0, halt: 1'b0};
    localparam ctrl_t CTRL_ITYPE = '{use_rs: 1'b1, use_rt: 1'b0, rd_sel: RD_FROM_RT,
        use_imm: 1'b1, branch: 1'b0, mem_read: 1'b0, mem_to_reg: 1'b0, mem_write: 1'b0, halt: 1'b0};
    localparam ctrl_t CTRL_LDW = '{use_rs: 1'b1, use_rt: 1'b0, rd_sel: RD_FROM_RT,
        use_imm: 1'b1, branch: 1'b0, mem_read: 1'b1, mem_to_reg: 1'b1, mem_write: 1'b0, halt: 1'b0};
    localparam ctrl_t CTRL_STW = '{use_rs: 1'b1, use_rt: 1'b1, rd_sel: RD_NONE,
        use_imm: 1'b1, branch: 1'b0, mem_read: 1'b0, mem_to_reg: 1'b0, mem_write: 1'b1, halt: 1'b0};
    localparam ctrl_t CTRL_BR_RS = '{use_rs: 1'b1, use_rt: 1'b0, rd_sel: RD_NONE,
        use_imm: 1'b1, branch: 1'b1, mem_read: 1'b0, mem_to_reg: 1'b0, mem_write: 1'b0, halt: 1'b0};
    localparam ctrl_t CTRL_BEQ = '{use_rs: 1'b1, use_rt: 1'b1, rd_sel: RD_NONE,
        use_imm: 1'b1, branch: 1'b1, mem_read: 1'b0, mem_to_reg: 1'b0, mem_write: 1'b0, halt: 1'b0};
    localparam ctrl_t CTRL_HALT = '{use_rs: 1'b0, use_rt: 1'b0, rd_sel: RD_NONE,
        use_imm: 1'b0, branch: 1'b0, mem_read: 1'b0, mem_to_reg: 1'b0, mem_write: 1'b0, halt: 1'b1};

    function automatic ctrl_t decode_op(input logic [5:0] op);
        ctrl_t c;
        c = CTRL_NOP;
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_OR, OP_AND, OP_XOR:       c = CTRL_RTYPE;
            OP_ADDI, OP_SUBI, OP_MULI, OP_ORI, OP_ANDI, OP_XORI: c = CTRL_ITYPE;
            OP_LDW:                                              c = CTRL_LDW;
            OP_STW:                                              c = CTRL_STW;
            OP_BZ, OP_JR:                                        c = CTRL_BR_RS;
            OP_BEQ:                                              c = CTRL_BEQ;
            OP_HALT:                                             c = CTRL_HALT;
            default:                                             c = CTRL_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/id_regfile.sv
// Architectural register file: one write port from WB, two combinational read
// ports with same-cycle write bypass; register 0 is hardwired to zero.
module id_regfile #(
    parameter int D_SIZE    = 32,
    parameter int NREGS     = 32,
    parameter int ADDR_LINE = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_we,
    input  logic [ADDR_LINE-1:0] i_waddr,
    input  logic [D_SIZE-1:0]    i_wdata,
    input  logic [ADDR_LINE-1:0] i_raddr_a,
    input  logic [ADDR_LINE-1:0] i_raddr_b,
    output logic [D_SIZE-1:0]    o_rdata_a,
    output logic [D_SIZE-1:0]    o_rdata_b
);

    logic [D_SIZE-1:0] r_regs [NREGS];
    logic              w_wr_en;

    assign w_wr_en = i_we && (i_waddr != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (w_wr_en) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = (i_raddr_a == '0)                     ? '0 :
                       (w_wr_en && (i_waddr == i_raddr_a)) ? i_wdata : r_regs[i_raddr_a];
    assign o_rdata_b = (i_raddr_b == '0)                     ? '0 :
                       (w_wr_en && (i_waddr == i_raddr_b)) ? i_wdata : r_regs[i_raddr_b];

endmodule

// File: rtl/id_stage_p.sv
// Instruction decode stage: register read with WB bypass, opcode decode,
// load-use interlock, flush/hold handling and the ID/EX pipeline register.
module id_stage_p #(
    parameter int D_SIZE    = 32,
    parameter int NREGS     = 32,
    parameter int ADDR_LINE = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_f_if,
    input  logic [31:0]          inst,
    input  logic [31:0]          pc_in_f_if,
    input  logic [31:0]          pc4_in_f_if,
    input  logic                 w_f_wb,
    input  logic [ADDR_LINE-1:0] addr_in_f_wb,
    input  logic [D_SIZE-1:0]    write_data_f_wb,
    input  logic                 flush_f_ex,
    input  logic                 hold_f_ex,
    output logic                 stall_2_if,
    output logic                 valid_2_ex,
    output logic [5:0]           opcode_2_ex,
    output logic [D_SIZE-1:0]    rs_reg_value_2_ex,
    output logic [D_SIZE-1:0]    rt_reg_value_2_ex,
    output logic [D_SIZE-1:0]    i_data_2_ex,
    output logic [ADDR_LINE-1:0] rd_add_value_2_ex,
    output logic [31:0]          pc_out_2_ex,
    output logic [31:0]          pc4_out_2_ex,
    output logic                 branch_2_ex,
    output logic                 mem_read_2_ex,
    output logic                 mem_to_reg_2_ex,
    output logic                 mem_write_2_ex,
    output logic                 halted
);
    import id_stage_p_pkg::*;

    logic [5:0]           w_op;
    logic [ADDR_LINE-1:0] w_rs_addr, w_rt_addr, w_rd_addr;
    logic [D_SIZE-1:0]    w_rs_val, w_rt_val, w_imm_sext;
    ctrl_t                w_ctrl;
    logic                 w_load_use, w_accept;

    assign w_op       = inst[31:26];
    assign w_rs_addr  = ADDR_LINE'(inst[25:21]);
    assign w_rt_addr  = ADDR_LINE'(inst[20:16]);
    assign w_rd_addr  = ADDR_LINE'(inst[15:11]);
    assign w_imm_sext = {{(D_SIZE-16){inst[15]}}, inst[15:0]};
    assign w_ctrl     = decode_op(w_op);

    id_regfile #(.D_SIZE(D_SIZE), .NREGS(NREGS), .ADDR_LINE(ADDR_LINE)) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .i_we      (w_f_wb),
        .i_waddr   (addr_in_f_wb),
        .i_wdata   (write_data_f_wb),
        .i_raddr_a (w_rs_addr),
        .i_raddr_b (w_rt_addr),
        .o_rdata_a (w_rs_val),
        .o_rdata_b (w_rt_val)
    );

    // A load in EX whose destination this instruction reads; cleared by the bubble it causes
    assign w_load_use = valid_f_if && valid_2_ex && mem_read_2_ex && (rd_add_value_2_ex != '0) &&
                        ((w_ctrl.use_rs && (rd_add_value_2_ex == w_rs_addr)) ||
                         (w_ctrl.use_rt && (rd_add_value_2_ex == w_rt_addr)));

    assign stall_2_if = hold_f_ex || halted || (w_load_use && !flush_f_ex);
    assign w_accept   = valid_f_if && !stall_2_if && !flush_f_ex && !halted;

    logic                 w_n_valid;
    logic [5:0]           w_n_opcode;
    logic [D_SIZE-1:0]    w_n_rs, w_n_rt, w_n_imm;
    logic [ADDR_LINE-1:0] w_n_rd;
    logic [31:0]          w_n_pc, w_n_pc4;
    logic                 w_n_branch, w_n_mem_read, w_n_mem_to_reg, w_n_mem_write;

    // Bubbles zero every field; opcode and PCs pass through for any accepted instruction
    always_comb begin
        w_n_valid      = 1'b0;
        w_n_opcode     = '0;
        w_n_rs         = '0;
        w_n_rt         = '0;
        w_n_imm        = '0;
        w_n_rd         = '0;
        w_n_pc         = '0;
        w_n_pc4        = '0;
        w_n_branch     = 1'b0;
        w_n_mem_read   = 1'b0;
        w_n_mem_to_reg = 1'b0;
        w_n_mem_write  = 1'b0;
        if (w_accept) begin
            w_n_valid      = 1'b1;
            w_n_opcode     = w_op;
            w_n_pc         = pc_in_f_if;
            w_n_pc4        = pc4_in_f_if;
            if (w_ctrl.use_rs)  w_n_rs  = w_rs_val;
            if (w_ctrl.use_rt)  w_n_rt  = w_rt_val;
            if (w_ctrl.use_imm) w_n_imm = w_imm_sext;
            case (w_ctrl.rd_sel)
                RD_FROM_RD: w_n_rd = w_rd_addr;
                RD_FROM_RT: w_n_rd = w_rt_addr;
                default:    w_n_rd = '0;
            endcase
            w_n_branch     = w_ctrl.branch;
            w_n_mem_read   = w_ctrl.mem_read;
            w_n_mem_to_reg = w_ctrl.mem_to_reg;
            w_n_mem_write  = w_ctrl.mem_write;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_2_ex        <= 1'b0;
            opcode_2_ex       <= '0;
            rs_reg_value_2_ex <= '0;
            rt_reg_value_2_ex <= '0;
            i_data_2_ex       <= '0;
            rd_add_value_2_ex <= '0;
            pc_out_2_ex       <= '0;
            pc4_out_2_ex      <= '0;
            branch_2_ex       <= 1'b0;
            mem_read_2_ex     <= 1'b0;
            mem_to_reg_2_ex   <= 1'b0;
            mem_write_2_ex    <= 1'b0;
            halted            <= 1'b0;
        end else begin
            if (w_accept && w_ctrl.halt) halted <= 1'b1;
            if (!hold_f_ex) begin
                valid_2_ex        <= w_n_valid;
                opcode_2_ex       <= w_n_opcode;
                rs_reg_value_2_ex <= w_n_rs;
                rt_reg_value_2_ex <= w_n_rt;
                i_data_2_ex       <= w_n_imm;
                rd_add_value_2_ex <= w_n_rd;
                pc_out_2_ex       <= w_n_pc;
                pc4_out_2_ex      <= w_n_pc4;
                branch_2_ex       <= w_n_branch;
                mem_read_2_ex     <= w_n_mem_read;
                mem_to_reg_2_ex   <= w_n_mem_to_reg;
                mem_write_2_ex    <= w_n_mem_write;
            end
        end
    end

endmodule

// File: doc/id_stage_p.md
ID_STAGE_P -- requirements
Module: id_stage_p

Interface
REQ-001 Parameter D_SIZE, default 32, register/data width in bits (>=16).
REQ-002 Parameter NREGS, default 32, number of architectural registers (power of two, >=2).
REQ-003 Parameter ADDR_LINE, default $clog2(NREGS), register address width.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-low: asserted when 0.
REQ-006 valid_f_if  input  1  inst, pc_in_f_if and pc4_in_f_if carry a real instruction.
REQ-007 inst  input  32  instruction from IF; opcode inst[31:26], rs [25:21], rt [20:16], rd [15:11], imm [15:0]; fields wider than ADDR_LINE use the low bits.
REQ-008 pc_in_f_if / pc4_in_f_if  input  32 each  PC and PC+4 from IF.
REQ-009 w_f_wb / addr_in_f_wb / write_data_f_wb  input  1 / ADDR_LINE / D_SIZE  WB write enable, address, data.
REQ-010 flush_f_ex  input  1  taken branch/jump in EX; discard the instruction in ID.
REQ-011 hold_f_ex  input  1  EX back-pressure; ID output register holds.
REQ-012 stall_2_if  output  1  combinational; IF must hold PC and re-present inst.
REQ-013 valid_2_ex, opcode_2_ex (6), rs_reg_value_2_ex, rt_reg_value_2_ex, i_data_2_ex (D_SIZE each), rd_add_value_2_ex (ADDR_LINE), pc_out_2_ex, pc4_out_2_ex (32 each), branch_2_ex, mem_read_2_ex, mem_to_reg_2_ex, mem_write_2_ex (1 each)  outputs  registered ID/EX pipeline fields.
REQ-014 halted  output  1  registered; sticky once HALT accepted.

Function
REQ-015 Register file: NREGS x D_SIZE flops; written at clock edge when w_f_wb=1 and addr_in_f_wb!=0; register 0 reads 0 always.
REQ-016 Read bypass: if w_f_wb=1, addr_in_f_wb!=0 and equals the read address, the read returns write_data_f_wb in the same cycle.
REQ-017 Opcodes: 0x00 ADD, 0x02 SUB, 0x04 MUL, 0x06 OR, 0x08 AND, 0x0A XOR: rs, rt values, rd=inst rd field, i_data=0.
REQ-018 0x01/03/05/07/09/0B immediate forms and 0x0C LDW: rs value, rt value 0, rd=rt field, i_data=imm; LDW sets mem_read=mem_to_reg=1.
REQ-019 0x0D STW: rs value, rt value (store data), rd=0, i_data=imm, mem_write=1.
REQ-020 0x0E BZ: rs, rt=0; 0x0F BEQ: rs, rt; 0x10 JR: rs, rt=0; all rd=0, i_data=imm, branch=1.
REQ-021 0x11 HALT and undefined opcodes: all data/control fields 0; valid_2_ex follows REQ-023.
REQ-022 imm sign-extended from bit 15 to D_SIZE.
REQ-023 accept = valid_f_if & !stall_2_if & !flush_f_ex & !halted; priority per cycle: hold_f_ex (output holds, stall_2_if=1) > flush_f_ex (bubble) > load-use (bubble) > accept (load decoded fields, valid_2_ex=1) > otherwise bubble.
REQ-024 Bubble: valid_2_ex=0 and branch/mem_read/mem_to_reg/mem_write=0; other fields don't-care but SHALL be 0.
REQ-025 Load-use: stall_2_if=1 when valid_2_ex=1, mem_read_2_ex=1, rd_add_value_2_ex!=0 and equals a source register the current valid instruction reads (rs; rt for R-type, STW, BEQ); lasts exactly one cycle per dependency.
REQ-026 flush_f_ex wins over load-use; stall_2_if=0 during flush unless hold_f_ex=1.
REQ-027 Latency: accepted instruction appears on outputs one cycle later.
REQ-028 Accepted HALT sets halted=1 at the same edge; thereafter all inputs bubbled, stall_2_if=1, until reset; WB writes still performed.

Reset
REQ-029 reset=0 asynchronously clears all register-file entries, all *_2_ex outputs and halted to 0.
REQ-030 Reset deassertion mid-stream: first edge after deassertion decodes normally; no residual stall.

Structure
REQ-031 Opcode enum, opcode-to-control record typedef and decode constants SHALL live in the shared package used with struct.sv.
REQ-032 Register file with bypass SHALL be one sub-module, id_regfile, parametrised by D_SIZE/NREGS.

Verification
REQ-033 WB writes r5=0x1234 while ADD r3,r5,r0 decodes in the same cycle -> next cycle rs_reg_value_2_ex=0x1234, rd=3, valid_2_ex=1.
REQ-034 Write r0=0xFFFF, then ADD r1,r0,r0 -> rs=rt=0.
REQ-035 LDW r4,0(r2) then ADD r6,r4,r1 -> one cycle stall_2_if=1 plus bubble, then ADD issues; ADD r6,r7,r1 -> no stall.
REQ-036 ADDI imm=0x8000, D_SIZE=64 build -> i_data_2_ex=0xFFFF_FFFF_FFFF_8000.
REQ-037 flush_f_ex=1 together with hold_f_ex=1, then flush alone -> held output unchanged, then bubble.
REQ-038 HALT then ADD; reset pulse mid-stream -> halted=1, ADD bubbled; after reset all outputs 0, halted=0.
